// File: rtl/hangman_game_reg.sv
// hangman_game_reg: word/guess tracking, win/loss detection, LED and LCD row generation for the hangman host.
module hangman_game_reg #(
    parameter int WORD_LEN     = 5,
    parameter int MAX_MISTAKES = 6,
    parameter int ROW_CHARS    = 16
) (
    input  logic                              clk,
    input  logic                              nRst,
    input  logic [8*WORD_LEN-1:0]             setWord,
    input  logic                              toggle_state,
    input  logic [7:0]                        msg,
    input  logic                              ready,
    input  logic                              gameEnd_host,
    output logic                              green,
    output logic                              red,
    output logic                              blue,
    output logic                              err_LED,
    output logic [$clog2(MAX_MISTAKES+1)-1:0] mistakes,
    output logic                              win,
    output logic                              loss,
    output logic [8*ROW_CHARS-1:0]            host_row1,
    output logic [8*ROW_CHARS-1:0]            host_row2
);
    localparam int MW = $clog2(MAX_MISTAKES+1);
    typedef enum logic [2:0] {IDLE, PLAY, CHECK, WIN, LOSS} state_t;
    state_t                state;
    logic [8*WORD_LEN-1:0] word;
    logic [WORD_LEN-1:0]   mask, hit, new_mask;
    logic [25:0]           guessed, gbit;
    logic [7:0]            guess, off;
    logic                  ready_q, valid, dup, miss;
    logic [MW-1:0]         new_mis;

    always_comb begin
        for (int i = 0; i < WORD_LEN; i++) hit[i] = word[8*(WORD_LEN-1-i) +: 8] == guess;
        off      = guess - 8'h41;
        valid    = guess >= 8'h41 && guess <= 8'h5A;
        gbit     = 26'd1 << off[4:0];
        dup      = |(guessed & gbit);
        miss     = valid && !dup && hit == '0;
        new_mask = valid && !dup ? mask | hit : mask;
        new_mis  = miss && mistakes != MW'(MAX_MISTAKES) ? mistakes + MW'(1) : mistakes;
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            state    <= IDLE;
            word     <= '0;
            mask     <= '0;
            guessed  <= '0;
            mistakes <= '0;
            guess    <= '0;
            ready_q  <= 1'b0;
            {green, red, blue, err_LED} <= '0;
        end else begin
            ready_q <= ready;
            if (toggle_state) begin
                word     <= setWord;
                mask     <= '0;
                guessed  <= '0;
                mistakes <= '0;
                {green, red, blue, err_LED} <= '0;
                state    <= PLAY;
            end else begin
                case (state)
                    PLAY: if (ready && !ready_q) begin
                        guess <= msg;
                        state <= CHECK;
                    end
                    CHECK: begin
                        green    <= valid && !dup && !miss;
                        red      <= miss;
                        blue     <= valid && dup;
                        err_LED  <= !valid;
                        mask     <= new_mask;
                        mistakes <= new_mis;
                        if (valid && !dup) guessed <= guessed | gbit;
                        state    <= &new_mask ? WIN : new_mis == MW'(MAX_MISTAKES) ? LOSS : PLAY;
                    end
                    WIN, LOSS: if (gameEnd_host) begin
                        state <= IDLE;
                        {green, red, blue, err_LED} <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign win  = state == WIN;
    assign loss = state == LOSS;

    always_comb begin
        host_row1 = {ROW_CHARS{8'h20}};
        host_row2 = {ROW_CHARS{8'h20}};
        if (state != IDLE)
            for (int i = 0; i < WORD_LEN; i++)
                host_row1[8*(ROW_CHARS-1-i) +: 8] = state == LOSS || mask[i] ? word[8*(WORD_LEN-1-i) +: 8] : 8'h5F;
        if (state == PLAY || state == CHECK)
            host_row2[8*ROW_CHARS-1 -: 64] = {"MISS ", 8'(mistakes) + 8'h30, "/", 8'(MAX_MISTAKES + 48)};
        else if (state == WIN)
            host_row2[8*ROW_CHARS-1 -: 56] = "YOU WIN";
        else if (state == LOSS)
            host_row2[8*ROW_CHARS-1 -: 64] = "YOU LOSE";
    end
endmodule

// File: tb/tb_hangman_game_reg.sv
// tb_hangman_game_reg: directed hangman games on default and 8-letter/3-mistake instances with a scoreboard.
module tb_hangman_game_reg;
    logic         clk = 0, nRst = 0, toggle = 0, toggle2 = 0, ready = 0, game_end = 0;
    logic [39:0]  set_word = '0;
    logic [63:0]  set_word2 = '0;
    logic [7:0]   msg = '0;
    logic         green, red, blue, err_led, win, loss;
    logic         g2, rd2, bl2, er2, win2, loss2;
    logic [2:0]   mis1;
    logic [1:0]   mis2;
    logic [127:0] row1, row2, row1_2, row2_2;

    typedef struct {
        string        tag;
        logic [3:0]   leds;
        logic [3:0]   mis;
        logic [1:0]   wl;
        logic [127:0] r1, r2;
    } exp_t;
    exp_t  sb[$];
    int    n_assert = 0, n_fail = 0;
    string phase = "";

    always #5 clk = ~clk;

    hangman_game_reg dut (
        .clk(clk), .nRst(nRst), .setWord(set_word), .toggle_state(toggle), .msg(msg), .ready(ready),
        .gameEnd_host(game_end), .green(green), .red(red), .blue(blue), .err_LED(err_led),
        .mistakes(mis1), .win(win), .loss(loss), .host_row1(row1), .host_row2(row2));

    hangman_game_reg #(.WORD_LEN(8), .MAX_MISTAKES(3), .ROW_CHARS(16)) dut2 (
        .clk(clk), .nRst(nRst), .setWord(set_word2), .toggle_state(toggle2), .msg(msg), .ready(ready),
        .gameEnd_host(game_end), .green(g2), .red(rd2), .blue(bl2), .err_LED(er2),
        .mistakes(mis2), .win(win2), .loss(loss2), .host_row1(row1_2), .host_row2(row2_2));

    function automatic logic [127:0] pad(input string s);
        logic [127:0] r = {16{8'h20}};
        for (int i = 0; i < s.len(); i++) r[8*(15-i) +: 8] = s[i];
        return r;
    endfunction

    task automatic push(input string tag, input logic [3:0] leds, input int mis, input logic [1:0] wl,
                        input string r1, input string r2);
        exp_t e;
        e.tag = tag; e.leds = leds; e.mis = 4'(mis); e.wl = wl; e.r1 = pad(r1); e.r2 = pad(r2);
        sb.push_back(e);
    endtask

    task automatic pop(input bit d2);
        exp_t e;
        logic [3:0] l, m;
        logic [1:0] wl;
        logic [127:0] r1, r2;
        if (sb.size() == 0) begin
            n_assert++; n_fail++;
            $error("FAIL scoreboard_empty got 0 entries exp >=1");
            return;
        end
        e  = sb.pop_front();
        l  = d2 ? {g2, rd2, bl2, er2} : {green, red, blue, err_led};
        m  = d2 ? 4'(mis2) : 4'(mis1);
        wl = d2 ? {win2, loss2} : {win, loss};
        r1 = d2 ? row1_2 : row1;
        r2 = d2 ? row2_2 : row2;
        n_assert++;
        assert (l === e.leds) else begin n_fail++; $error("FAIL %s leds(g,r,b,e) got %b exp %b", e.tag, l, e.leds); end
        n_assert++;
        assert (m === e.mis) else begin n_fail++; $error("FAIL %s mistakes got %0d exp %0d", e.tag, m, e.mis); end
        n_assert++;
        assert (wl === e.wl) else begin n_fail++; $error("FAIL %s win/loss got %b exp %b", e.tag, wl, e.wl); end
        n_assert++;
        assert (r1 === e.r1) else begin n_fail++; $error("FAIL %s row1 got '%s' exp '%s'", e.tag, r1, e.r1); end
        n_assert++;
        assert (r2 === e.r2) else begin n_fail++; $error("FAIL %s row2 got '%s' exp '%s'", e.tag, r2, e.r2); end
    endtask

    task automatic new_game(input bit d2, input logic [63:0] w);
        if (d2) begin set_word2 = w; toggle2 = 1; end
        else begin set_word = w[39:0]; toggle = 1; end
        @(negedge clk);
        toggle = 0; toggle2 = 0;
        @(negedge clk);
    endtask

    task automatic g(input bit d2, input logic [7:0] c, input logic [3:0] leds, input int mis,
                     input logic [1:0] wl, input string r1, input string r2);
        push($sformatf("%s:%c", phase, c), leds, mis, wl, r1, r2);
        msg = c; ready = 1;
        @(negedge clk);
        ready = 0;
        @(negedge clk);
        pop(d2);
    endtask

    initial begin
        phase = "reset";
        repeat (2) @(negedge clk);
        nRst = 1;
        push("reset", 4'b0000, 0, 2'b00, "", "");
        pop(0);
        push("reset2", 4'b0000, 0, 2'b00, "", "");
        pop(1);

        phase = "moore";
        new_game(0, "MOORE");
        push("moore_start", 4'b0000, 0, 2'b00, "_____", "MISS 0/6");
        pop(0);
        g(0, "O", 4'b1000, 0, 2'b00, "_OO__", "MISS 0/6");
        g(0, "P", 4'b0100, 1, 2'b00, "_OO__", "MISS 1/6");
        g(0, "M", 4'b1000, 1, 2'b00, "MOO__", "MISS 1/6");
        g(0, "M", 4'b0010, 1, 2'b00, "MOO__", "MISS 1/6");
        g(0, "R", 4'b1000, 1, 2'b00, "MOOR_", "MISS 1/6");
        g(0, "E", 4'b1000, 1, 2'b10, "MOORE", "YOU WIN");
        game_end = 1;
        @(negedge clk);
        game_end = 0;
        push("game_end", 4'b0000, 1, 2'b00, "", "");
        pop(0);

        phase = "invalid";
        new_game(0, "MOORE");
        g(0, 8'h35, 4'b0001, 0, 2'b00, "_____", "MISS 0/6");
        g(0, 8'h61, 4'b0001, 0, 2'b00, "_____", "MISS 0/6");
        g(0, 8'h40, 4'b0001, 0, 2'b00, "_____", "MISS 0/6");
        g(0, 8'h5B, 4'b0001, 0, 2'b00, "_____", "MISS 0/6");
        g(0, "Z", 4'b0100, 1, 2'b00, "_____", "MISS 1/6");

        phase = "latency";
        new_game(0, "MOORE");
        msg = "M"; ready = 1;
        @(negedge clk);
        ready = 0;
        n_assert++;
        assert (green === 1'b0) else begin n_fail++; $error("FAIL lat_edge1 green got %b exp 0", green); end
        @(negedge clk);
        n_assert++;
        assert (green === 1'b1) else begin n_fail++; $error("FAIL lat_edge2 green got %b exp 1", green); end

        phase = "priority";
        set_word = "YUMMY"; toggle = 1; msg = "I"; ready = 1;
        @(negedge clk);
        toggle = 0; ready = 0;
        repeat (2) @(negedge clk);
        push("prio_drop", 4'b0000, 0, 2'b00, "_____", "MISS 0/6");
        pop(0);

        phase = "loss";
        g(0, "I", 4'b0100, 1, 2'b00, "_____", "MISS 1/6");
        g(0, "L", 4'b0100, 2, 2'b00, "_____", "MISS 2/6");
        g(0, "K", 4'b0100, 3, 2'b00, "_____", "MISS 3/6");
        g(0, "N", 4'b0100, 4, 2'b00, "_____", "MISS 4/6");
        g(0, "J", 4'b0100, 5, 2'b00, "_____", "MISS 5/6");
        g(0, "F", 4'b0100, 6, 2'b01, "YUMMY", "YOU LOSE");
        g(0, "Q", 4'b0100, 6, 2'b01, "YUMMY", "YOU LOSE");

        phase = "midreset";
        new_game(0, "YUMMY");
        g(0, "I", 4'b0100, 1, 2'b00, "_____", "MISS 1/6");
        g(0, "L", 4'b0100, 2, 2'b00, "_____", "MISS 2/6");
        nRst = 0;
        @(negedge clk);
        nRst = 1;
        push("mid_reset", 4'b0000, 0, 2'b00, "", "");
        pop(0);
        new_game(0, "YUMMY");
        push("clean_start", 4'b0000, 0, 2'b00, "_____", "MISS 0/6");
        pop(0);
        g(0, "Y", 4'b1000, 0, 2'b00, "Y___Y", "MISS 0/6");
        g(0, "L", 4'b0100, 1, 2'b00, "Y___Y", "MISS 1/6");

        phase = "sweep";
        new_game(1, "ABCDEFGH");
        push("sweep_start", 4'b0000, 0, 2'b00, "________", "MISS 0/3");
        pop(1);
        g(1, "H", 4'b1000, 0, 2'b00, "_______H", "MISS 0/3");
        g(1, "X", 4'b0100, 1, 2'b00, "_______H", "MISS 1/3");
        g(1, "Y", 4'b0100, 2, 2'b00, "_______H", "MISS 2/3");
        g(1, "Z", 4'b0100, 3, 2'b01, "ABCDEFGH", "YOU LOSE");
        g(1, "W", 4'b0100, 3, 2'b01, "ABCDEFGH", "YOU LOSE");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
